// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp encodings, the control bundle and its bubble value.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int ALUOP_W_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [ALUOP_W_DEF-1:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_RTYPE = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4,
    ALUOP_SLT   = 3'd5
  } aluOp_e;

  // Single-bit decoder controls carried from ID to EX, in port order.
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic memRead;
    logic memWrite;
    logic branch;
    logic aluSrc;
    logic regDst;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection and PC / IF/ID write-enable generation.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             idValid,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             flush,
  output logic             hazard,
  output logic             pcWrite,
  output logic             ifIdWrite
);

  logic rtMatch;

  assign rtMatch = (exRt == idRs) || (exRt == idRt);

  // A load targeting $0 never produces a dependency.
  assign hazard = idValid && exValid && exMemRead && (exRt != '0) && rtMatch;

  // A flush squashes the stalled instruction, so fetch must keep moving.
  assign pcWrite   = !hazard || flush;
  assign ifIdWrite = !hazard || flush;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating
// stall/flush event counters.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               ID_Valid,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_Branch,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_SignExt,
  input  logic [DATA_W-1:0]  ID_PC4,
  input  logic [REG_W-1:0]   ID_RegisterRs,
  input  logic [REG_W-1:0]   ID_RegisterRt,
  input  logic [REG_W-1:0]   ID_RegisterRd,
  input  logic               Flush,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic               ID_EX_Valid,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_Branch,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegDst,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_ReadData1,
  output logic [DATA_W-1:0]  ID_EX_ReadData2,
  output logic [DATA_W-1:0]  ID_EX_SignExt,
  output logic [DATA_W-1:0]  ID_EX_PC4,
  output logic [REG_W-1:0]   ID_EX_RegisterRs,
  output logic [REG_W-1:0]   ID_EX_RegisterRt,
  output logic [REG_W-1:0]   ID_EX_RegisterRd,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic  hazard;
  logic  loadBubble;
  ctrl_t idCtrl;
  ctrl_t exCtrl;

  load_use_detect #(.REG_W(REG_W)) uDetect (
    .idValid   (ID_Valid),
    .exValid   (ID_EX_Valid),
    .exMemRead (ID_EX_MemRead),
    .exRt      (ID_EX_RegisterRt),
    .idRs      (ID_RegisterRs),
    .idRt      (ID_RegisterRt),
    .flush     (Flush),
    .hazard    (hazard),
    .pcWrite   (PCWrite),
    .ifIdWrite (IF_ID_Write)
  );

  assign idCtrl = '{regWrite: ID_RegWrite, memtoReg: ID_MemtoReg, memRead: ID_MemRead,
                    memWrite: ID_MemWrite, branch: ID_Branch, aluSrc: ID_ALUSrc,
                    regDst: ID_RegDst};

  assign loadBubble = Flush || hazard || !ID_Valid;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_Valid      <= 1'b0;
      exCtrl           <= BUBBLE_CTRL;
      ID_EX_ALUOp      <= '0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExt    <= '0;
      ID_EX_PC4        <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
    end else if (loadBubble) begin
      ID_EX_Valid      <= 1'b0;
      exCtrl           <= BUBBLE_CTRL;
      ID_EX_ALUOp      <= '0;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExt    <= '0;
      ID_EX_PC4        <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
    end else begin
      ID_EX_Valid      <= 1'b1;
      exCtrl           <= idCtrl;
      ID_EX_ALUOp      <= ID_ALUOp;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_SignExt    <= ID_SignExt;
      ID_EX_PC4        <= ID_PC4;
      ID_EX_RegisterRs <= ID_RegisterRs;
      ID_EX_RegisterRt <= ID_RegisterRt;
      ID_EX_RegisterRd <= ID_RegisterRd;
    end
  end

  assign ID_EX_RegWrite = exCtrl.regWrite;
  assign ID_EX_MemtoReg = exCtrl.memtoReg;
  assign ID_EX_MemRead  = exCtrl.memRead;
  assign ID_EX_MemWrite = exCtrl.memWrite;
  assign ID_EX_Branch   = exCtrl.branch;
  assign ID_EX_ALUSrc   = exCtrl.aluSrc;
  assign ID_EX_RegDst   = exCtrl.regDst;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (hazard && !Flush && (StallCount != '1)) StallCount <= StallCount + CNT_ONE;
      if (Flush && ID_Valid && (FlushCount != '1)) FlushCount <= FlushCount + CNT_ONE;
    end
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection and bubble/flush insertion.
- Upstream: ID stage (decoder, register file, sign extender).
- Downstream: EX stage. Its registered RegisterRs/RegisterRt feed the forwarding unit; its operands feed the ALU forwarding muxes.
- Also produces the PC and IF/ID write-enables for stalling, plus two stall/flush performance counters.

Parameters:
- DATA_W, 32, datapath and operand width
- REG_W, 5, register-number width
- ALUOP_W, 3, ALUOp field width
- CNT_W, 16, performance-counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_Valid  in  1  IF/ID holds a real instruction
- ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc, ID_RegDst  in  1 each  decoder control
- ID_ALUOp  in  ALUOP_W  decoder ALU op
- ID_ReadData1, ID_ReadData2, ID_SignExt, ID_PC4  in  DATA_W each  operands, immediate, PC+4
- ID_RegisterRs, ID_RegisterRt, ID_RegisterRd  in  REG_W each  instruction register fields
- Flush  in  1  branch taken in EX/MEM; squash the instruction in ID
- PCWrite  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUSrc, ID_EX_RegDst  out  1 each  registered
- ID_EX_ALUOp  out  ALUOP_W  registered
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExt, ID_EX_PC4  out  DATA_W each  registered
- ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd  out  REG_W each  registered
- StallCount, FlushCount  out  CNT_W each  saturating counters

Behaviour:
- Reset (rst_n low, asynchronous): all ID_EX_* outputs and both counters are 0. PCWrite and IF_ID_Write are combinational, so they evaluate to 1 during reset (no ID_EX_MemRead is held).
- Load-use detect, combinational:
  - hazard = ID_Valid & ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegisterRt != 0) & (ID_EX_RegisterRt == ID_RegisterRs | ID_EX_RegisterRt == ID_RegisterRt).
  - PCWrite = IF_ID_Write = ~hazard | Flush.
- Each rising edge, priority order:
  1. Flush = 1: load a bubble. Valid and all control outputs become 0; data and register fields become 0. Flush overrides hazard (the stalled instruction is on the wrong path).
  2. hazard = 1: load a bubble, as above. The ID instruction is held by IF_ID_Write = 0 and re-presented next cycle.
  3. ID_Valid = 0: load a bubble.
  4. Otherwise: capture every ID_* input into its ID_EX_* output; ID_EX_Valid = 1.
- Latency: 1 cycle ID to EX. A load-use stall inserts exactly 1 bubble, because after the bubble ID_EX_MemRead = 0 and the hazard clears.
- StallCount increments on each edge where hazard & ~Flush. FlushCount increments on each edge where Flush & ID_Valid. Both saturate at all-ones and never wrap.
- No state machine beyond the pipeline register. Back-to-back loads with dependencies stall once per dependent pair.
- Reset deassertion mid-stream: the first post-reset edge behaves normally. Asserting rst_n low mid-stall clears the register immediately.

Decomposition:
- Shared package pipe_pkg: ALUOp encodings, REG_ZERO = 0, the control-bundle field list, and the bubble value (all-zero control).
- Natural sub-module: load_use_detect, combinational, computing hazard and the two enables.
- Pipeline register and counters stay in the top.

Test Plan:
- Reset: rst_n = 0 with random ID inputs -> all ID_EX_* = 0, counters 0, PCWrite = IF_ID_Write = 1. Release rst_n, present add $3,$1,$2 valid -> next edge ID_EX_RegisterRs = 1, Rt = 2, Rd = 3, ID_EX_RegWrite = 1, ID_EX_Valid = 1.
- Load-use: lw $5,0($1), then add $6,$5,$2 -> PCWrite = IF_ID_Write = 0 for 1 cycle. Next edge ID_EX_Valid = 0 with all controls 0, StallCount = 1. Following edge the add is captured with ID_EX_RegisterRs = 5.
- No false stall: lw $0,0($1), then add $6,$0,$2 -> no hazard, StallCount stays 0. Also lw $5, then add $6,$7,$8 -> no stall.
- Flush over hazard: hazard condition with Flush = 1 in the same cycle -> PCWrite = 1, bubble loaded, FlushCount = 1, StallCount unchanged.
- Invalid ID: ID_Valid = 0 with ID_MemWrite = 1 -> ID_EX_MemWrite = 0, ID_EX_Valid = 0.
- Saturation and async reset: force 2^CNT_W + 3 stalls -> StallCount = 0xFFFF. Pulse rst_n low between clock edges -> outputs clear before the next edge.
